// File: rtl/capture_pkg.sv
// Shared types and constants for the FIR capture / AXIS packing stage.
package capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   localparam logic [3:0] BEAT_KEEP = 4'hF;
   localparam int         SAMPLE_W  = 16;
   localparam int         BEAT_W    = 2 * SAMPLE_W;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty.
// Occupancy includes the output stage, so total capacity is exactly DEPTH.
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [PW-1:0]    occ_reg, occ_next;
   logic [WIDTH-1:0] dout_reg;
   logic             dout_valid_reg, full_reg, empty_reg;
   logic             do_wr, do_pop, mem_empty, do_load;

   assign do_wr     = wr_en && !full_reg;
   assign do_pop    = rd_en && dout_valid_reg;
   assign mem_empty = (wr_ptr_reg == rd_ptr_reg);
   // Refill the output stage whenever it is free or being consumed this cycle.
   assign do_load   = !mem_empty && (!dout_valid_reg || do_pop);

   always_comb begin
      occ_next = occ_reg;
      if (do_wr)  occ_next = occ_next + PW'(1);
      if (do_pop) occ_next = occ_next - PW'(1);
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         occ_reg        <= '0;
         dout_reg       <= '0;
         dout_valid_reg <= 1'b0;
         full_reg       <= 1'b0;
         empty_reg      <= 1'b1;
      end else begin
         if (do_wr) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (do_load) begin
            dout_reg       <= mem[rd_ptr_reg[AW-1:0]];
            dout_valid_reg <= 1'b1;
            rd_ptr_reg     <= rd_ptr_reg + PW'(1);
         end else if (do_pop) begin
            dout_valid_reg <= 1'b0;
         end
         occ_reg   <= occ_next;
         full_reg  <= (occ_next == PW'(DEPTH));
         empty_reg <= (occ_next == '0);
      end
   end

   assign rd_data  = dout_reg;
   assign rd_valid = dout_valid_reg;
   assign full     = full_reg;
   assign empty    = empty_reg;

endmodule

// File: rtl/dut_capture_packer.sv
// Packs pairs of 16-bit DUT samples into 32-bit AXIS beats, framed with
// tlast every PKT_BEATS beats or at the end of a cfg_len-beat capture.
module dut_capture_packer
   import capture_pkg::*;
#(
   parameter int PKT_BEATS  = 256,
   parameter int FIFO_DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic [31:0] cfg_len,
   input  logic [15:0] sample_in,
   input  logic        sample_valid,
   output logic [31:0] m_axis_tdata,
   output logic [3:0]  m_axis_tkeep,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        busy,
   output logic        done,
   output logic [15:0] ovf_cnt
);

   localparam int             PCW      = $clog2(PKT_BEATS);
   localparam logic [PCW-1:0] PKT_LAST = PCW'(PKT_BEATS - 1);

   state_t          state_reg;
   logic [31:0]     len_reg, word_cnt_reg;
   logic [PCW-1:0]  pkt_cnt_reg;
   logic            half_reg;
   logic [15:0]     low_reg;
   logic [15:0]     ovf_reg;

   logic            fifo_full, fifo_empty, fifo_valid;
   logic [32:0]     fifo_dout;
   logic            pair_done, len_hit, beat_last, beat_wr;

   assign pair_done = (state_reg == ST_CAPTURE) && sample_valid && half_reg;
   assign len_hit   = (len_reg != '0) && (word_cnt_reg == len_reg - 32'd1);
   assign beat_last = (pkt_cnt_reg == PKT_LAST) || len_hit;
   assign beat_wr   = pair_done && !fifo_full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         len_reg      <= '0;
         word_cnt_reg <= '0;
         pkt_cnt_reg  <= '0;
         half_reg     <= 1'b0;
         low_reg      <= '0;
         ovf_reg      <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  len_reg      <= cfg_len;
                  word_cnt_reg <= '0;
                  pkt_cnt_reg  <= '0;
                  half_reg     <= 1'b0;
                  ovf_reg      <= '0;
                  state_reg    <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (sample_valid) begin
                  if (!half_reg) begin
                     low_reg  <= sample_in;
                     half_reg <= 1'b1;
                  end else begin
                     half_reg     <= 1'b0;
                     word_cnt_reg <= word_cnt_reg + 32'd1;
                     if (!fifo_full)
                        pkt_cnt_reg <= beat_last ? '0 : pkt_cnt_reg + PCW'(1);
                     else if (ovf_reg != 16'hFFFF)
                        ovf_reg <= ovf_reg + 16'd1;
                  end
               end
               // A beat completing alongside stop is still kept; a lone half is discarded.
               if (stop || (pair_done && len_hit)) begin
                  half_reg  <= 1'b0;
                  state_reg <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (33),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (beat_wr),
      .wr_data  ({beat_last, sample_in, low_reg}),
      .rd_en    (m_axis_tready),
      .rd_data  (fifo_dout),
      .rd_valid (fifo_valid),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign m_axis_tdata  = fifo_dout[31:0];
   assign m_axis_tlast  = fifo_valid && fifo_dout[32];
   assign m_axis_tvalid = fifo_valid;
   assign m_axis_tkeep  = fifo_valid ? BEAT_KEEP : 4'h0;
   assign busy          = (state_reg != ST_IDLE);
   assign done          = (state_reg == ST_DRAIN) && fifo_empty;
   assign ovf_cnt       = ovf_reg;

endmodule

// File: tb/tb_dut_capture_packer.sv
// Randomised bench for dut_capture_packer against a sample-list reference model.
module tb_dut_capture_packer;

   localparam int PKT   = 8;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] cfg_len = '0;
   logic [15:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] ovf_cnt;

   dut_capture_packer #(
      .PKT_BEATS  (PKT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .stop          (stop),
      .cfg_len       (cfg_len),
      .sample_in     (sample_in),
      .sample_valid  (sample_valid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .done          (done),
      .ovf_cnt       (ovf_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] sent_q[$];
   beat_t       rx_q[$];
   beat_t       exp_q[$];
   int          done_cnt = 0;
   bit          stab_en = 0;
   int          stab_bad = 0;
   logic        hold_prev = 1'b0;
   logic [31:0] data_prev = '0;
   logic        last_prev = 1'b0;

   // Output monitor: collects transferred beats, done pulses, hold violations.
   always @(negedge clk) begin
      if (m_axis_tvalid && m_axis_tready) rx_q.push_back(beat_t'{m_axis_tdata, m_axis_tlast});
      if (done) done_cnt++;
      if (stab_en && hold_prev &&
          (!m_axis_tvalid || m_axis_tdata !== data_prev || m_axis_tlast !== last_prev))
         stab_bad++;
      hold_prev = m_axis_tvalid && !m_axis_tready;
      data_prev = m_axis_tdata;
      last_prev = m_axis_tlast;
   end

   // Reference: beat i (1-based) = {s[2i-1], s[2i-2]}; last on packet multiples or the cfg_len-th beat.
   function automatic void build_expected(input int len, input int max_wr);
      int nb;
      exp_q.delete();
      nb = sent_q.size() / 2;
      if (len != 0 && nb > len) nb = len;
      if (nb > max_wr) nb = max_wr;
      for (int i = 1; i <= nb; i++)
         exp_q.push_back(beat_t'{{sent_q[2*i-1], sent_q[2*i-2]},
                                 ((i % PKT) == 0) || (len != 0 && i == len)});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] len);
      start   = 1'b1;
      cfg_len = len;
      tick();
      start   = 1'b0;
   endtask

   task automatic send(input logic [15:0] s);
      sample_in    = s;
      sample_valid = 1'b1;
      sent_q.push_back(s);
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int c0;
      c0 = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done_cnt != c0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, busy, done} !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_ctrl: got v=%b l=%b k=%h busy=%b done=%b, want all 0",
                  m_axis_tvalid, m_axis_tlast, m_axis_tkeep, busy, done);
      end
      n_cmp++;
      if (m_axis_tdata !== 32'h0 || ovf_cnt !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_data: got tdata=%h ovf=%0d, want 0/0", m_axis_tdata, ovf_cnt);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bit ok;
      int d0;
      sent_q.delete();
      rx_q.delete();
      m_axis_tready = 1'b1;
      d0 = done_cnt;
      do_start(4);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_busy: got %b want 1", busy);
      end
      for (int i = 1; i <= 8; i++) send(16'(i));
      wait_done(50, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL basic_done_timeout: got no done, want done");
      end
      repeat (3) tick();
      build_expected(4, 1 << 30);
      n_cmp++;
      if (rx_q.size() != 4 || exp_q.size() != 4 || rx_q[0].data !== 32'h00020001) begin
         n_bad++;
         $display("FAIL basic_first: got %0d beats, want 4 starting 00020001", rx_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         $display("basic beat %0d: data=%h last=%b", i, rx_q[i].data, rx_q[i].last);
         n_cmp++;
         if (rx_q[i].data !== exp_q[i].data || rx_q[i].last !== exp_q[i].last) begin
            n_bad++;
            $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i, rx_q[i].data,
                     rx_q[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
      n_cmp++;
      if (done_cnt - d0 != 1 || ovf_cnt !== 16'h0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_end: got done_pulses=%0d ovf=%0d busy=%b, want 1/0/0",
                  done_cnt - d0, ovf_cnt, busy);
      end
   endtask

   task automatic test_framing();
      bit ok;
      int nsent;
      sent_q.delete();
      rx_q.delete();
      m_axis_tready = 1'b1;
      do_start(20);
      nsent = 0;
      while (nsent < 40) begin
         if ($urandom_range(0, 3) != 0) begin
            send(16'($urandom));
            nsent++;
         end else begin
            tick();
         end
      end
      wait_done(50, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL framing_done_timeout: got no done, want done");
      end
      build_expected(20, 1 << 30);
      n_cmp++;
      if (rx_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL framing_count: got %0d want %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         $display("framing beat %0d: data=%h last=%b", i, rx_q[i].data, rx_q[i].last);
         n_cmp++;
         if (rx_q[i].data !== exp_q[i].data || rx_q[i].last !== exp_q[i].last) begin
            n_bad++;
            $display("FAIL framing_beat%0d: got %h/%b want %h/%b", i, rx_q[i].data,
                     rx_q[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   task automatic test_overflow();
      bit ok;
      sent_q.delete();
      rx_q.delete();
      m_axis_tready = 1'b0;
      do_start(10);
      for (int i = 0; i < 20; i++) send(16'($urandom));
      repeat (3) tick();
      n_cmp++;
      if (ovf_cnt !== 16'd6 || m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_count: got ovf=%0d tvalid=%b busy=%b, want 6/1/1",
                  ovf_cnt, m_axis_tvalid, busy);
      end
      m_axis_tready = 1'b1;
      wait_done(50, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL ovf_done_timeout: got no done, want done");
      end
      build_expected(10, DEPTH);
      n_cmp++;
      if (rx_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL ovf_beats: got %0d want %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         $display("ovf beat %0d: data=%h last=%b", i, rx_q[i].data, rx_q[i].last);
         n_cmp++;
         if (rx_q[i].data !== exp_q[i].data || rx_q[i].last !== exp_q[i].last) begin
            n_bad++;
            $display("FAIL ovf_beat%0d: got %h/%b want %h/%b", i, rx_q[i].data,
                     rx_q[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   task automatic test_early_stop();
      bit ok;
      sent_q.delete();
      rx_q.delete();
      m_axis_tready = 1'b1;
      do_start(0);
      for (int i = 0; i < 5; i++) send(16'($urandom));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done(50, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL stop_done_timeout: got no done, want done");
      end
      build_expected(0, 1 << 30);
      n_cmp++;
      if (rx_q.size() != 2 || exp_q.size() != 2) begin
         n_bad++;
         $display("FAIL stop_count: got %0d want 2", rx_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         $display("stop beat %0d: data=%h last=%b", i, rx_q[i].data, rx_q[i].last);
         n_cmp++;
         if (rx_q[i].data !== exp_q[i].data || rx_q[i].last !== exp_q[i].last) begin
            n_bad++;
            $display("FAIL stop_beat%0d: got %h/%b want %h/%b", i, rx_q[i].data,
                     rx_q[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   task automatic test_back_pressure();
      bit ok;
      sent_q.delete();
      rx_q.delete();
      stab_bad = 0;
      m_axis_tready = 1'b1;
      do_start(0);
      stab_en = 1'b1;
      // tready high at least every other cycle keeps the FIFO from filling.
      for (int c = 0; c < 300; c++) begin
         m_axis_tready = (c % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) != 0) begin
            sample_in    = 16'($urandom);
            sample_valid = 1'b1;
            sent_q.push_back(sample_in);
         end else begin
            sample_valid = 1'b0;
         end
         tick();
      end
      sample_valid = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      m_axis_tready = 1'b1;
      wait_done(50, ok);
      stab_en = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL bp_done_timeout: got no done, want done");
      end
      n_cmp++;
      if (stab_bad != 0 || ovf_cnt !== 16'h0) begin
         n_bad++;
         $display("FAIL bp_hold: got hold_violations=%0d ovf=%0d, want 0/0", stab_bad, ovf_cnt);
      end
      build_expected(0, 1 << 30);
      n_cmp++;
      if (rx_q.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL bp_count: got %0d want %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         $display("bp beat %0d: data=%h last=%b", i, rx_q[i].data, rx_q[i].last);
         n_cmp++;
         if (rx_q[i].data !== exp_q[i].data || rx_q[i].last !== exp_q[i].last) begin
            n_bad++;
            $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, rx_q[i].data,
                     rx_q[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      sent_q.delete();
      rx_q.delete();
      m_axis_tready = 1'b0;
      do_start(0);
      for (int i = 0; i < 12; i++) send(16'($urandom));
      repeat (2) tick();
      n_cmp++;
      if (ovf_cnt !== 16'd2 || m_axis_tvalid !== 1'b1) begin
         n_bad++;
         $display("FAIL rmid_pre: got ovf=%0d tvalid=%b, want 2/1", ovf_cnt, m_axis_tvalid);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, busy, done} !== 8'h00 ||
          m_axis_tdata !== 32'h0 || ovf_cnt !== 16'h0) begin
         n_bad++;
         $display("FAIL rmid_outputs: got v=%b l=%b k=%h d=%h busy=%b done=%b ovf=%0d, want 0",
                  m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, busy, done, ovf_cnt);
      end
      tick();
      sent_q.delete();
      rx_q.delete();
      m_axis_tready = 1'b1;
      do_start(2);
      for (int i = 0; i < 4; i++) send(16'($urandom));
      wait_done(50, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL rmid_done_timeout: got no done, want done");
      end
      build_expected(2, 1 << 30);
      n_cmp++;
      if (rx_q.size() != exp_q.size() || ovf_cnt !== 16'h0) begin
         n_bad++;
         $display("FAIL rmid_count: got %0d beats ovf=%0d, want %0d/0",
                  rx_q.size(), ovf_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         $display("rmid beat %0d: data=%h last=%b", i, rx_q[i].data, rx_q[i].last);
         n_cmp++;
         if (rx_q[i].data !== exp_q[i].data || rx_q[i].last !== exp_q[i].last) begin
            n_bad++;
            $display("FAIL rmid_beat%0d: got %h/%b want %h/%b", i, rx_q[i].data,
                     rx_q[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_basic();
      test_framing();
      test_overflow();
      test_early_stop();
      test_back_pressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, want $finish before 500us");
      $fatal(1);
   end

endmodule
